alu_word_sequencer: RTL
=======================

# alu_word_sequencer

Multi-cycle controller that runs 16-bit word operations (INW, DEW, ASW, ROW) through the shared 8-bit ALU. Each operation takes two ALU passes, low byte then high byte, and chains the carry between them. The block sits between the CPU microsequencer and the ALU. It owns the ALU input and control lines while busy and collects the registered ALU results into a 16-bit word plus C/Z/N flags.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; takes priority over every other input.
- rdy  in  1  global ready; when low, the FSM and all outputs hold and alu_rdy=0.
- start  in  1  command request; sampled only in IDLE with rdy=1.
- cmd  in  2  00 INW (+1), 01 DEW (-1), 10 ASW (shift left, 0 in), 11 ROW (rotate left through carry).
- din  in  16  operand; latched on command acceptance.
- cin  in  1  carry in for ROW; latched on acceptance; ignored for the other commands.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse (while rdy=1) when the result is valid.
- dout  out  16  result; holds its value until the next done.
- cout  out  1  carry out of bit 15.
- z  out  1  1 when dout==0 (full 16-bit test).
- n  out  1  dout[15].
- alu_op  out  4  ALU opcode.
- alu_ai  out  8  ALU AI.
- alu_bi  out  8  ALU BI.
- alu_ci  out  1  ALU carry in.
- alu_right  out  1  tied 0.
- alu_arith  out  1  tied 0.
- alu_bcd  out  1  tied 0.
- alu_rdy  out  1  ALU clock enable.
- alu_out  in  8  registered ALU result.
- alu_co  in  1  registered ALU carry.
- alu_n  in  1  registered ALU N.

## Operation
- States: IDLE, LO, HI, WB. The state encoding is internal.
- IDLE -> LO when start=1 and rdy=1. On that edge, latch din, cmd, cin.
- LO -> HI -> WB -> IDLE unconditionally, each transition gated by rdy=1.
- Op mapping and carry:
  - INW: alu_op=0011, alu_bi=0; LO uses alu_ci=1.
  - DEW: alu_op=0111, alu_bi=0; LO uses alu_ci=0, so the ALU computes A+FF.
  - ASW: alu_op=1011, alu_bi=0; LO uses alu_ci=0.
  - ROW: alu_op=1011, alu_bi=0; LO uses alu_ci=cin_latched.
  - HI, all commands: alu_ci=alu_co, which holds the carry from the LO pass.
- LO: alu_ai=din[7:0], alu_rdy=rdy.
- HI: alu_ai=din[15:8], alu_rdy=rdy. On the exiting edge, capture alu_out into the low-byte holding register.
- WB: alu_rdy=0. On the exiting edge:
  - dout={alu_out, low byte}.
  - cout=alu_co, n=alu_n.
  - z=(alu_out==0 && low byte==0).
  - done<=1.
- IDLE and WB: alu_ai=0, alu_bi=0, alu_ci=0, alu_op=latched op.
- done: registered, cleared on the next rdy=1 edge. If rdy is low, done stretches.
- DEW carry convention: cout=1 means no borrow.
- ALU V output unused.

## Timing
- Reset values: state=IDLE, busy=0, done=0, dout=0000, cout=0, z=0, n=0, alu_rdy=0, latched operands 0.
- Latency with rdy held high: start high in cycle 0 gives busy in cycles 1-3 and done in cycle 4.
- Throughput: a new start is accepted in the same cycle done is high, so back-to-back commands run every 4 cycles.
- start while busy is ignored; it is not queued. Changes to din/cmd/cin after acceptance have no effect.
- rdy low in any state: no transition, alu_rdy=0, so the ALU holds its registers. Each low cycle adds one cycle of latency.
- reset in LO/HI/WB: return to IDLE on that edge. The command is aborted, done is not asserted, and dout and flags go to their reset values.
- reset and start together: reset wins, and the block is IDLE in the next cycle.

## Test plan
- INW din=00FF: done in cycle 4, dout=0100, cout=0, z=0, n=0. INW din=FFFF: dout=0000, cout=1, z=1, n=0.
- DEW din=0000: dout=FFFF, cout=0, n=1, z=0. DEW din=0100: dout=00FF, cout=1.
- ASW din=8001: dout=0002, cout=1. ROW din=4000, cin=1: dout=8001, cout=0, n=1.
- rdy low for 2 cycles in HI during INW 12FF: done in cycle 6, dout=1300, alu_rdy=0 during the stall. start pulsed in cycle 2: ignored, only one done.
- reset asserted in HI: next cycle busy=0, done=0, dout=0000. done never pulses. A fresh INW 0001 then returns 0002 in 4 cycles.
- Back-to-back: INW 0000 in cycle 0 and ASW 0003 in cycle 4 give done in cycle 4 (0001) and cycle 8 (0006).

Source files
------------

// File: rtl/alu_word_sequencer.sv
// Sequences 16-bit INW/DEW/ASW/ROW through an 8-bit registered ALU: low byte, then high byte with carry chained.
// Latency: start accepted in cycle 0 -> busy cycles 1-3 -> done pulse in cycle 4; rdy low stalls everything.
module alu_word_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic [15:0] din,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic        cout,
    output logic        z,
    output logic        n,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_right,
    output logic        alu_arith,
    output logic        alu_bcd,
    output logic        alu_rdy,
    input  logic [7:0]  alu_out,
    input  logic        alu_co,
    input  logic        alu_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [1:0] CMD_INW = 2'b00;
    localparam logic [1:0] CMD_DEW = 2'b01;
    localparam logic [1:0] CMD_ASW = 2'b10;

    logic [1:0]  state;
    logic [15:0] din_q;
    logic [1:0]  cmd_q;
    logic        cin_q;
    logic [7:0]  lo_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            dout    <= 16'h0000;
            cout    <= 1'b0;
            z       <= 1'b0;
            n       <= 1'b0;
            din_q   <= 16'h0000;
            cmd_q   <= 2'b00;
            cin_q   <= 1'b0;
            lo_byte <= 8'h00;
        end else if (rdy) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LO;
                        din_q <= din;
                        cmd_q <= cmd;
                        cin_q <= cin;
                    end
                end
                S_LO: state <= S_HI;
                S_HI: begin
                    state   <= S_WB;
                    lo_byte <= alu_out;
                end
                S_WB: begin
                    state <= S_IDLE;
                    dout  <= {alu_out, lo_byte};
                    cout  <= alu_co;
                    n     <= alu_n;
                    z     <= (alu_out == 8'h00) && (lo_byte == 8'h00);
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign alu_right = 1'b0;
    assign alu_arith = 1'b0;
    assign alu_bcd   = 1'b0;
    assign alu_bi    = 8'h00;

    // ASW and ROW share the shift opcode; they differ only in the low-pass carry in.
    always_comb begin
        case (cmd_q)
            CMD_INW: alu_op = 4'b0011;
            CMD_DEW: alu_op = 4'b0111;
            default: alu_op = 4'b1011;
        endcase
    end

    always_comb begin
        alu_ai  = 8'h00;
        alu_ci  = 1'b0;
        alu_rdy = 1'b0;
        case (state)
            S_LO: begin
                alu_ai  = din_q[7:0];
                alu_rdy = rdy;
                case (cmd_q)
                    CMD_INW: alu_ci = 1'b1;
                    CMD_DEW: alu_ci = 1'b0;
                    CMD_ASW: alu_ci = 1'b0;
                    default: alu_ci = cin_q;
                endcase
            end
            S_HI: begin
                alu_ai  = din_q[15:8];
                alu_ci  = alu_co;
                alu_rdy = rdy;
            end
            default: ;
        endcase
    end

endmodule
